ptmch_spi_slave: RTL and testbench

SPI mode-0 slave front end of ptmch_top. It terminates the host's 24-clock frame: 8-bit instruction, 8-bit address, then 8 read-data clocks.
- Instruction and address are captured in the SPI_CLK domain.
- Read data is returned on MISO.
- Each complete command is handed to the CLK160M domain as a one-cycle CMD_VALID pulse, consumed by the trigger/control logic that drives TRG_PLS.

---
 rtl/ptmch_spi_pkg.sv | 22 ++
 rtl/ptmch_tgl_sync.sv | 28 ++
 rtl/ptmch_spi_slave.sv | 124 ++++++++++++
 tb/tb_ptmch_spi_slave.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/ptmch_spi_pkg.sv
// Shared constants and the command record for the ptmch SPI slave front end.
`timescale 1ns/1ps
package ptmch_spi_pkg;

   localparam logic [7:0] RD_STAT = 8'h0F;
   localparam logic [7:0] RD_ID   = 8'h05;

   localparam logic [7:0] ADDR_A0 = 8'hA0;
   localparam logic [7:0] ADDR_B0 = 8'hB0;
   localparam logic [7:0] ADDR_C0 = 8'hC0;

   // Frame bit positions, sized to the 5-bit SPI bit counter.
   localparam logic [4:0] BIT_INST  = 5'd8;
   localparam logic [4:0] BIT_HDR   = 5'd16;
   localparam logic [4:0] BIT_FRAME = 5'd24;

   typedef struct packed {
      logic [7:0] inst;
      logic [7:0] addr;
   } cmd_t;

endpackage

// File: rtl/ptmch_tgl_sync.sv
// Toggle-to-pulse synchroniser: SYNC_STAGES flop chain plus an edge-detect register.
`timescale 1ns/1ps
module ptmch_tgl_sync #(
   parameter int unsigned SYNC_STAGES = 3
) (
   input  logic clk,
   input  logic rst,
   input  logic tgl,
   output logic pls
);

   logic [SYNC_STAGES-1:0] sync;
   logic                   prev;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync <= '0;
         prev <= 1'b0;
      end else begin
         sync <= {sync[SYNC_STAGES-2:0], tgl};
         prev <= sync[SYNC_STAGES-1];
      end
   end

   // Both operands are flops in this domain, so the pulse is glitch-free.
   assign pls = sync[SYNC_STAGES-1] ^ prev;

endmodule

// File: rtl/ptmch_spi_slave.sv
// SPI mode-0 slave: 8-bit instruction, 8-bit address, 8 read clocks; each full
// header is handed to CLK160M as a one-cycle CMD_VALID with the decoded command.
`timescale 1ns/1ps
module ptmch_spi_slave
   import ptmch_spi_pkg::*;
#(
   parameter logic [7:0]  INST_RD_STAT = RD_STAT,
   parameter logic [7:0]  INST_RD_ID   = RD_ID,
   parameter logic [7:0]  ID_VALUE     = 8'hA5,
   parameter int unsigned SYNC_STAGES  = 3
) (
   input  logic       CLK160M,
   input  logic       RESET_N,
   input  logic       SPI_CS,
   input  logic       SPI_CLK,
   input  logic       SPI_MOSI,
   output logic       SPI_MISO,
   output logic       SPI_MISO_OE,
   input  logic [7:0] STAT_A0,
   input  logic [7:0] STAT_B0,
   input  logic [7:0] STAT_C0,
   output logic       CMD_VALID,
   output logic [7:0] CMD_INST,
   output logic [7:0] CMD_ADDR
);

   logic        spi_clr;
   logic [4:0]  bitcnt;
   logic [14:0] sh;
   cmd_t        hold;
   logic        cmd_tgl;
   logic [7:0]  rd_data;
   logic        rd_ok;
   logic [7:0]  osh;
   logic        rd_en;
   logic        cmd_edge;
   logic        cmd_valid;
   cmd_t        cmd;

   // Deasserting chip select wipes the frame state so every frame starts clean.
   assign spi_clr = RESET_N | SPI_CS;

   always_ff @(posedge SPI_CLK or posedge spi_clr) begin
      if (spi_clr) begin
         bitcnt <= '0;
         sh     <= '0;
      end else begin
         if (bitcnt != BIT_FRAME)
            bitcnt <= bitcnt + 5'd1;
         if (bitcnt < BIT_HDR)
            sh <= {sh[13:0], SPI_MOSI};
      end
   end

   // Header holding regs survive CS so the CLK160M side can read them later.
   always_ff @(posedge SPI_CLK or posedge RESET_N) begin
      if (RESET_N) begin
         hold    <= '0;
         cmd_tgl <= 1'b0;
      end else if (bitcnt == BIT_HDR - 5'd1) begin
         hold.inst <= sh[14 -: BIT_INST];
         hold.addr <= {sh[6:0], SPI_MOSI};
         cmd_tgl   <= ~cmd_tgl;
      end
   end

   assign rd_ok = (hold.inst == INST_RD_STAT) || (hold.inst == INST_RD_ID);

   // STAT_* are quasi-static around the address phase, so no synchroniser here.
   always_comb begin
      rd_data = 8'h00;
      if (hold.inst == INST_RD_ID) begin
         rd_data = ID_VALUE;
      end else if (hold.inst == INST_RD_STAT) begin
         case (hold.addr)
            ADDR_A0: rd_data = STAT_A0;
            ADDR_B0: rd_data = STAT_B0;
            ADDR_C0: rd_data = STAT_C0;
            default: rd_data = 8'h00;
         endcase
      end
   end

   always_ff @(negedge SPI_CLK or posedge spi_clr) begin
      if (spi_clr) begin
         osh   <= '0;
         rd_en <= 1'b0;
      end else if (bitcnt == BIT_HDR) begin
         osh   <= rd_data;
         rd_en <= rd_ok;
      end else begin
         osh <= {osh[6:0], 1'b0};
      end
   end

   assign SPI_MISO    = rd_en & osh[7];
   assign SPI_MISO_OE = rd_en & ~SPI_CS;

   ptmch_tgl_sync #(
      .SYNC_STAGES (SYNC_STAGES)
   ) u_tgl_sync (
      .clk (CLK160M),
      .rst (RESET_N),
      .tgl (cmd_tgl),
      .pls (cmd_edge)
   );

   // Capture alongside the registered pulse so the command is valid with CMD_VALID.
   always_ff @(posedge CLK160M or posedge RESET_N) begin
      if (RESET_N) begin
         cmd_valid <= 1'b0;
         cmd       <= '0;
      end else begin
         cmd_valid <= cmd_edge;
         if (cmd_edge)
            cmd <= hold;
      end
   end

   assign CMD_VALID = cmd_valid;
   assign CMD_INST  = cmd.inst;
   assign CMD_ADDR  = cmd.addr;

endmodule

// File: tb/tb_ptmch_spi_slave.sv
// Directed bench for ptmch_spi_slave: SPI host model, CMD_VALID monitor, hand-computed vectors.
`timescale 1ns/1ps
module tb_ptmch_spi_slave;

   localparam int HALF = 5;

   logic       CLK160M;
   logic       RESET_N;
   logic       SPI_CS;
   logic       SPI_CLK;
   logic       SPI_MOSI;
   logic       SPI_MISO;
   logic       SPI_MISO_OE;
   logic [7:0] STAT_A0;
   logic [7:0] STAT_B0;
   logic [7:0] STAT_C0;
   logic       CMD_VALID;
   logic [7:0] CMD_INST;
   logic [7:0] CMD_ADDR;

   int n_chk = 0;
   int n_err = 0;
   int pulse_cnt = 0;
   int wide_cnt = 0;
   int exp_n = 0;
   logic prev_v = 1'b0;
   logic [15:0] cmd_q[$];

   ptmch_spi_slave dut (
      .CLK160M     (CLK160M),
      .RESET_N     (RESET_N),
      .SPI_CS      (SPI_CS),
      .SPI_CLK     (SPI_CLK),
      .SPI_MOSI    (SPI_MOSI),
      .SPI_MISO    (SPI_MISO),
      .SPI_MISO_OE (SPI_MISO_OE),
      .STAT_A0     (STAT_A0),
      .STAT_B0     (STAT_B0),
      .STAT_C0     (STAT_C0),
      .CMD_VALID   (CMD_VALID),
      .CMD_INST    (CMD_INST),
      .CMD_ADDR    (CMD_ADDR)
   );

   initial CLK160M = 1'b0;
   always #3.125 CLK160M = ~CLK160M;

   always @(negedge CLK160M) begin
      if (CMD_VALID === 1'b1) begin
         pulse_cnt++;
         cmd_q.push_back({CMD_INST, CMD_ADDR});
         if (prev_v) wide_cnt++;
      end
      prev_v = (CMD_VALID === 1'b1);
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic spi_frame(input string tag, input logic [7:0] inst, input logic [7:0] addr,
                            input int nclk, input logic [7:0] exp_rd, input bit exp_oe);
      logic [15:0] hdr;
      logic [7:0]  rd;
      int          bad;
      hdr = {inst, addr};
      rd  = '0;
      bad = 0;
      SPI_CS = 1'b0;
      for (int i = 0; i < nclk; i++) begin
         SPI_MOSI = (i < 16) ? hdr[15-i] : 1'b0;
         #(HALF-1);
         if (SPI_MISO_OE !== (exp_oe && i >= 16)) bad++;
         if (i >= 16 && i < 24) rd[23-i] = SPI_MISO;
         else if (SPI_MISO !== 1'b0) bad++;
         #1 SPI_CLK = 1'b1;
         #HALF SPI_CLK = 1'b0;
      end
      #HALF SPI_CS = 1'b1;
      #1;
      if (nclk >= 24) chk({tag, " rd"}, {24'd0, rd}, {24'd0, exp_rd});
      chk({tag, " oe/miso bits"}, bad, 0);
      chk({tag, " oe release"}, {30'd0, SPI_MISO_OE, SPI_MISO}, 0);
   endtask

   task automatic wait_cmd(input string tag, input int exp_cnt, input logic [15:0] exp_cmd);
      for (int k = 0; k < 40 && pulse_cnt < exp_cnt; k++) @(posedge CLK160M);
      repeat (8) @(posedge CLK160M);
      #1;
      chk({tag, " cmd cnt"}, pulse_cnt, exp_cnt);
      chk({tag, " cmd"}, {16'd0, CMD_INST, CMD_ADDR}, {16'd0, exp_cmd});
   endtask

   logic [7:0] b_inst [6] = '{8'h0F, 8'h05, 8'h0F, 8'h0F, 8'h77, 8'h0F};
   logic [7:0] b_addr [6] = '{8'hC0, 8'h11, 8'hA0, 8'h12, 8'hB0, 8'hB0};
   logic [7:0] b_rd   [6] = '{8'hFF, 8'hA5, 8'h3C, 8'h00, 8'h00, 8'h81};
   bit         b_oe   [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};

   initial begin
      logic [7:0] st_addr [3];
      logic [7:0] st_val  [3];
      int q0;
      st_addr = '{8'hA0, 8'hB0, 8'hC0};
      st_val  = '{8'h3C, 8'h81, 8'hFF};

      RESET_N  = 1'b1;
      SPI_CS   = 1'b1;
      SPI_CLK  = 1'b0;
      SPI_MOSI = 1'b0;
      STAT_A0  = 8'h3C;
      STAT_B0  = 8'h81;
      STAT_C0  = 8'hFF;
      #100;
      chk("rst miso", {31'd0, SPI_MISO}, 0);
      chk("rst oe", {31'd0, SPI_MISO_OE}, 0);
      chk("rst valid", {31'd0, CMD_VALID}, 0);
      chk("rst inst", {24'd0, CMD_INST}, 0);
      chk("rst addr", {24'd0, CMD_ADDR}, 0);
      RESET_N = 1'b0;
      #50;

      for (int k = 0; k < 3; k++) begin
         spi_frame("stat", 8'h0F, st_addr[k], 24, st_val[k], 1'b1);
         exp_n++;
         wait_cmd("stat", exp_n, {8'h0F, st_addr[k]});
      end

      for (int k = 0; k < 3; k++) begin
         spi_frame("id", 8'h05, st_addr[k], 24, 8'hA5, 1'b1);
         exp_n++;
         wait_cmd("id", exp_n, {8'h05, st_addr[k]});
      end

      spi_frame("unk", 8'h33, 8'hA0, 24, 8'h00, 1'b0);
      exp_n++;
      wait_cmd("unk", exp_n, 16'h33A0);

      spi_frame("abort", 8'h0F, 8'hC0, 12, 8'h00, 1'b0);
      wait_cmd("abort", exp_n, 16'h33A0);

      spi_frame("post abort", 8'h0F, 8'hB0, 24, 8'h81, 1'b1);
      exp_n++;
      wait_cmd("post abort", exp_n, 16'h0FB0);

      spi_frame("noclk", 8'h0F, 8'hA0, 0, 8'h00, 1'b0);
      wait_cmd("noclk", exp_n, 16'h0FB0);

      spi_frame("extra", 8'h05, 8'h00, 28, 8'hA5, 1'b1);
      exp_n++;
      wait_cmd("extra", exp_n, 16'h0500);

      q0 = cmd_q.size();
      for (int k = 0; k < 6; k++) begin
         spi_frame("b2b", b_inst[k], b_addr[k], 24, b_rd[k], b_oe[k]);
         #($urandom_range(200, 50));
      end
      exp_n += 6;
      wait_cmd("b2b", exp_n, {b_inst[5], b_addr[5]});
      chk("b2b qsize", cmd_q.size() - q0, 6);
      for (int k = 0; k < 6; k++)
         if (q0 + k < cmd_q.size())
            chk("b2b order", {16'd0, cmd_q[q0+k]}, {16'd0, b_inst[k], b_addr[k]});
      chk("pulse width", wide_cnt, 0);

      SPI_CS = 1'b0;
      for (int i = 0; i < 10; i++) begin
         SPI_MOSI = (i < 8) ? 1'b1 : 1'b0;
         #HALF SPI_CLK = 1'b1;
         #HALF SPI_CLK = 1'b0;
      end
      RESET_N = 1'b1;
      #1;
      chk("midrst miso", {31'd0, SPI_MISO}, 0);
      chk("midrst oe", {31'd0, SPI_MISO_OE}, 0);
      chk("midrst valid", {31'd0, CMD_VALID}, 0);
      chk("midrst cmd", {16'd0, CMD_INST, CMD_ADDR}, 0);
      SPI_CS = 1'b1;
      #20 RESET_N = 1'b0;
      #20;
      wait_cmd("midrst", exp_n, 16'h0000);

      spi_frame("post rst", 8'h0F, 8'hC0, 24, 8'hFF, 1'b1);
      exp_n++;
      wait_cmd("post rst", exp_n, 16'h0FC0);
      chk("pulse width end", wide_cnt, 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
